// File: rtl/imm_raster_scan_pkg.sv
// Shared constants and FSM encoding for the image-masking raster feeder.
package imm_raster_scan_pkg;

    localparam int IMG_W_DEF  = 320;
    localparam int IMG_H_DEF  = 240;
    localparam int PIX_W_DEF  = 12;
    localparam int ADDR_W_DEF = 17;
    localparam int I_W        = 9;
    localparam int J_W        = 8;
    localparam int COORD_W    = I_W + J_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/imm_raster_scan_skid_fifo.sv
// Two-entry FIFO absorbing the one-cycle memory latency; head is always entry 0.
module imm_raster_scan_skid_fifo #(
    parameter int DW = 29
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [1:0]    occ,
    output logic [DW-1:0] head
);

    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    cnt;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0  <= '0;
            d1  <= '0;
            cnt <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) d0 <= din;
                    else             d1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    d0  <= d1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (cnt == 2'd1) begin
                        d0 <= din;
                    end else begin
                        d0 <= d1;
                        d1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ  = cnt;
    assign head = d0;

endmodule

// File: rtl/imm_raster_scan.sv
// Raster-scans one frame from synchronous memory and streams {pixel, i, j} beats.
module imm_raster_scan
    import imm_raster_scan_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  pixel,
    output logic [I_W-1:0]    i_p,
    output logic [J_W-1:0]    j_p
);

    localparam int DW = PIX_W + COORD_W;
    localparam logic [I_W-1:0] I_LAST = I_W'(IMG_W - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(IMG_H - 1);

    state_t            state;
    state_t            state_nx;
    logic [I_W-1:0]    i_cnt;
    logic [J_W-1:0]    j_cnt;
    logic [ADDR_W-1:0] addr;
    logic              inflight;
    logic [I_W-1:0]    i_fl;
    logic [J_W-1:0]    j_fl;
    logic [1:0]        occ;
    logic [DW-1:0]     head;
    logic              pop;
    logic              rd_en;
    logic              last_pop;
    logic [2:0]        level;

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    // Projected buffer fill after this cycle, before any new issue.
    assign level     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign last_pop  = pop && (occ == 2'd1) && !inflight;

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_SCAN;
            end
            ST_SCAN: begin
                rd_en = (level < 3'd2);
                if (rd_en && (i_cnt == I_LAST) && (j_cnt == J_LAST)) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_pop) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == ST_DRAIN) && last_pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_cnt    <= '0;
            j_cnt    <= '0;
            addr     <= '0;
            inflight <= 1'b0;
            i_fl     <= '0;
            j_fl     <= '0;
        end else begin
            inflight <= rd_en;
            if ((state == ST_IDLE) && start) begin
                i_cnt <= '0;
                j_cnt <= '0;
                addr  <= '0;
            end else if (rd_en) begin
                i_fl <= i_cnt;
                j_fl <= j_cnt;
                addr <= addr + 1'b1;
                if (i_cnt == I_LAST) begin
                    i_cnt <= '0;
                    j_cnt <= j_cnt + 1'b1;
                end else begin
                    i_cnt <= i_cnt + 1'b1;
                end
            end
        end
    end

    imm_raster_scan_skid_fifo #(.DW(DW)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .pop  (pop),
        .din  ({mem_rdata, i_fl, j_fl}),
        .occ  (occ),
        .head (head)
    );

    assign busy      = (state != ST_IDLE);
    assign mem_rd_en = rd_en;
    assign mem_addr  = addr;
    assign pixel     = head[DW-1:COORD_W];
    assign i_p       = head[COORD_W-1:J_W];
    assign j_p       = head[J_W-1:0];

endmodule

// File: tb/tb_imm_raster_scan.sv
// Directed bench for imm_raster_scan: a 4x3 frame instance plus a 320-wide instance.
module tb_imm_raster_scan;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int BW = 320;
    localparam int BH = 3;
    localparam int BN = BW * BH;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, out_ready;
    logic        busy, done, mem_rd_en, out_valid;
    logic [16:0] mem_addr;
    logic [11:0] mem_rdata, pixel;
    logic [8:0]  i_p;
    logic [7:0]  j_p;

    logic        start_b, ready_b;
    logic        busy_b, done_b, rd_en_b, valid_b;
    logic [16:0] addr_b;
    logic [11:0] rdata_b, pixel_b;
    logic [8:0]  i_b;
    logic [7:0]  j_b;

    imm_raster_scan #(.IMG_W(W), .IMG_H(H), .PIX_W(12), .ADDR_W(17)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .pixel(pixel), .i_p(i_p), .j_p(j_p)
    );

    imm_raster_scan #(.IMG_W(BW), .IMG_H(BH), .PIX_W(12), .ADDR_W(17)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .out_valid(valid_b), .out_ready(ready_b), .pixel(pixel_b), .i_p(i_b), .j_p(j_b)
    );

    function automatic logic [11:0] pix_of(input int a);
        return 12'((a * 73 + 19) ^ (a >> 3));
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= pix_of(int'(mem_addr));
        if (rd_en_b)   rdata_b   <= pix_of(int'(addr_b));
    end

    typedef struct {
        logic [8:0] i;
        logic [7:0] j;
        int         addr;
    } beat_t;

    beat_t       tbl [N];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          beats, issued, dones, last_acc, done_cyc, max_out;
    logic [28:0] prev;
    logic        prev_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_on_start", 64'(busy), 64'(1));
    endtask

    // mode 0: always ready, 1: random ready, 2: stalled 10 cycles, 5: extra start pulses
    task automatic consume(input int mode, input int abort_at);
        int          cyc;
        bit          fin;
        logic [28:0] cur;
        beats = 0; issued = 0; dones = 0; last_acc = -1; done_cyc = -1; max_out = 0;
        prev_stall = 1'b0; prev = '0; cyc = 0; fin = 0;
        while (!fin) begin
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (cyc >= 10);
                default: out_ready = 1'b1;
            endcase
            start = (mode == 5) && (cyc == 3 || cyc == 8);
            #1;
            cur = {pixel, i_p, j_p};
            if (prev_stall) check("hold", 64'(cur), 64'(prev));
            if (mode == 2 && cyc == 9) begin
                check("stall_reads", 64'(issued), 64'(2));
                check("stall_addr", 64'(mem_addr), 64'(2));
            end
            if (mem_rd_en) issued++;
            if (out_valid && out_ready) begin
                if (beats < N) begin
                    check("beat", 64'(cur),
                          64'({pix_of(tbl[beats].addr), tbl[beats].i, tbl[beats].j}));
                end else begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_beat: got beat %0d expected at most %0d", beats + 1, N);
                end
                beats++;
                if (beats == N) last_acc = cyc;
            end
            if (issued - beats > max_out) max_out = issued - beats;
            prev_stall = out_valid && !out_ready;
            prev = cur;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (done) begin
                dones++;
                done_cyc = cyc;
                check("busy_at_done", 64'(busy), 64'(0));
            end
            if (abort_at > 0 && beats == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("abort_outputs_zero",
                      64'({busy, done, mem_rd_en, mem_addr, out_valid, pixel, i_p, j_p}), 64'(0));
                repeat (2) @(posedge clk);
                #2 rst = 1'b0;
                fin = 1;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 3) fin = 1;
            if (cyc > 300) begin
                n_cmp++; n_fail++;
                $display("FAIL timeout: got %0d beats expected %0d within 300 cycles", beats, N);
                fin = 1;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic post_checks();
        check("beat_count", 64'(beats), 64'(N));
        check("done_count", 64'(dones), 64'(1));
        check("done_timing", 64'(done_cyc), 64'(last_acc + 1));
        check("outstanding_le2", 64'(max_out <= 2), 64'(1));
        check("busy_after", 64'(busy), 64'(0));
    endtask

    initial begin
        int k, bad, last_i, last_j, max_a, bcyc;

        tbl[0]  = '{9'd0, 8'd0, 0};  tbl[1]  = '{9'd1, 8'd0, 1};
        tbl[2]  = '{9'd2, 8'd0, 2};  tbl[3]  = '{9'd3, 8'd0, 3};
        tbl[4]  = '{9'd0, 8'd1, 4};  tbl[5]  = '{9'd1, 8'd1, 5};
        tbl[6]  = '{9'd2, 8'd1, 6};  tbl[7]  = '{9'd3, 8'd1, 7};
        tbl[8]  = '{9'd0, 8'd2, 8};  tbl[9]  = '{9'd1, 8'd2, 9};
        tbl[10] = '{9'd2, 8'd2, 10}; tbl[11] = '{9'd3, 8'd2, 11};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0; start_b = 1'b0; ready_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({busy, done, mem_rd_en, mem_addr, out_valid, pixel, i_p, j_p}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        do_start(); consume(0, -1); post_checks();
        do_start(); consume(1, -1); post_checks();
        do_start(); consume(2, -1); post_checks();

        do_start(); consume(0, 5);
        dones = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("no_done_after_abort", 64'(dones), 64'(0));
        check("idle_after_abort", 64'(busy), 64'(0));
        do_start(); consume(0, -1); post_checks();

        do_start(); consume(5, -1); post_checks();
        repeat (2) @(posedge clk);
        #1;
        check("no_rescan", 64'(busy), 64'(0));

        start_b = 1'b1; ready_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        k = 0; bad = 0; last_i = -1; last_j = -1; max_a = -1; bcyc = 0;
        while (!done_b && bcyc < 2000) begin
            #1;
            if (rd_en_b && int'(addr_b) > max_a) max_a = int'(addr_b);
            if (valid_b) begin
                if ({pixel_b, i_b, j_b} !== {pix_of(k), 9'(k % BW), 8'(k / BW)}) bad++;
                last_i = int'(i_b); last_j = int'(j_b);
                k++;
            end
            @(posedge clk); #1;
            bcyc++;
        end
        check("big_done_seen", 64'(done_b), 64'(1));
        check("big_beat_count", 64'(k), 64'(BN));
        check("big_beats_in_order", 64'(bad), 64'(0));
        check("big_last_i", 64'(last_i), 64'(BW - 1));
        check("big_last_j", 64'(last_j), 64'(BH - 1));
        check("big_last_addr", 64'(max_a), 64'(BN - 1));
        check("big_busy_at_done", 64'(busy_b), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
